// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
//   Shared constants and types for the 32-entry architectural register bank.
//   DATA_WIDTH     : width of one architectural register
//   REG_COUNT      : number of registers in the bank
//   REG_ADDR_WIDTH : width of a register index
//   data_t         : one register's worth of data
package reg_bank_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bit_cell.sv
// reg_bit_cell
//   One storage bit: D flip-flop with synchronous reset to a per-bit value
//   and a write enable.
//   clk     : clock, rising edge active
//   reset   : synchronous active-high reset, dominates the enable
//   rst_val : value taken on reset
//   en      : write enable; anything other than a solid 1 holds
//   d       : write data
//   q       : stored bit, straight from the flop
module reg_bit_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic en,
    input  logic d,
    output logic q
);

    // An unknown enable takes the else path of the if, so an X on en holds
    // the stored value instead of smearing X into q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg_bit_cell

// File: rtl/reg_nbits.sv
// reg_nbits
//   N-bit parallel-load register, one per architectural register in the bank.
//   Write data is shared across the bank; each instance has its own load.
//   clk   : clock, rising edge active
//   reset : synchronous active-high reset, loads RESET_VALUE, beats load
//   load  : write strobe, x captured on the next rising edge
//   x     : write data
//   x_out : stored value, driven directly from flops
module reg_nbits
    import reg_bank_pkg::*;
#(
    parameter int             N           = DATA_WIDTH,
    parameter logic [N-1:0]   RESET_VALUE = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] x,
    output logic [N-1:0] x_out
);

    if (N < 1 || N > 128) begin : g_bad_width
        $fatal(1, "reg_nbits: N=%0d outside legal range 1..128", N);
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        reg_bit_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .en      (load),
            .d       (x[i]),
            .q       (x_out[i])
        );
    end

    // Contents must be fully known once reset has been applied.
    a_known_after_reset : assert property (
        @(posedge clk) reset |=> !$isunknown(x_out)
    ) else $error("reg_nbits: x_out unknown after reset");

    // Nothing may disturb the value on an edge with neither reset nor load.
    a_hold_stable : assert property (
        @(posedge clk) (reset === 1'b0 && load !== 1'b1) |=> $stable(x_out)
    ) else $error("reg_nbits: x_out changed without reset or load");

endmodule : reg_nbits

// File: tb/tb_reg_nbits.sv
module tb_reg_nbits;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [63:0] x;
    logic [63:0] x_out;

    logic        reset8;
    logic        load8;
    logic [7:0]  x8;
    logic [7:0]  x_out8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_nbits u_dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .x     (x),
        .x_out (x_out)
    );

    reg_nbits #(.N(8), .RESET_VALUE(8'h5A)) u_dut8 (
        .clk   (clk),
        .reset (reset8),
        .load  (load8),
        .x     (x8),
        .x_out (x_out8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1; load  = 1'b1; x  = 64'hFFFF_FFFF_FFFF_FFFF;
        reset8 = 1'b1; load8 = 1'b1; x8 = 8'hFF;
        step();
        check("reset64", x_out, 64'h0);
        check("reset8", {56'h0, x_out8}, 64'h5A);

        reset  = 1'b0; load  = 1'b1; x  = 64'h0123_4567_89AB_CDEF;
        reset8 = 1'b0; load8 = 1'b1; x8 = 8'hC3;
        step();
        check("load64", x_out, 64'h0123_4567_89AB_CDEF);
        check("load8", {56'h0, x_out8}, 64'hC3);

        load  = 1'b0; x  = 64'hDEAD_BEEF_0000_0001;
        load8 = 1'b0; x8 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold64_%0d", i), x_out, 64'h0123_4567_89AB_CDEF);
        end
        check("hold8", {56'h0, x_out8}, 64'hC3);

        load = 1'bx;
        step();
        check("hold_load_x", x_out, 64'h0123_4567_89AB_CDEF);

        load = 1'b1;
        x = 64'd1; step(); check("b2b_1", x_out, 64'd1);
        x = 64'd2; step(); check("b2b_2", x_out, 64'd2);
        x = 64'd3; step(); check("b2b_3", x_out, 64'd3);

        reset = 1'b1; load = 1'b1; x = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        check("prio_reset", x_out, 64'h0);

        reset = 1'b0; load = 1'b1; x = 64'd5;
        step();
        check("resume_load", x_out, 64'd5);

        load = 1'b0; x = 64'hFFFF_0000_FFFF_0000;
        step();
        check("hold_after_resume", x_out, 64'd5);

        load = 1'b1; x = 64'h8000_0000_0000_0001;
        step();
        check("edge_bits", x_out, 64'h8000_0000_0000_0001);

        reset8 = 1'b1; load8 = 1'b1; x8 = 8'h11;
        step();
        check("reset8_again", {56'h0, x_out8}, 64'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_nbits
